// File: rtl/i2s2_tx_if.sv
// Sample handshake bundle between the synthesizer and the I2S transmitter.
// A stereo pair (left/right, two's complement) is transferred on a cycle where
// sample_valid_in and sample_ready_out are both high.
//   master: drives sample_l_in, sample_r_in, sample_valid_in; reads sample_ready_out
//   slave : reads the pair and valid; drives sample_ready_out
interface i2s2_tx_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] sample_l_in;
  logic [WIDTH-1:0] sample_r_in;
  logic             sample_valid_in;
  logic             sample_ready_out;

  modport master (
    output sample_l_in,
    output sample_r_in,
    output sample_valid_in,
    input  sample_ready_out
  );

  modport slave (
    input  sample_l_in,
    input  sample_r_in,
    input  sample_valid_in,
    output sample_ready_out
  );
endinterface

// File: rtl/i2s2_tx.sv
// I2S transmitter for the Pmod I2S2 DAC path.
// Derives MCLK, SCLK and LRCK from clk_in, buffers stereo pairs in a small FIFO and
// serialises each channel as 24-bit Philips I2S, MSB first, one SCLK after the LRCK edge.
// A new pair is taken from the FIFO at every frame boundary (last cycle of bit 63).
//
// Ports:
//   clk_in       : audio clock (98.3 MHz)
//   n_rst_in     : asynchronous active-low reset
//   sample_if    : slave side of the sample valid/ready handshake (i2s2_tx_if)
//   mclk_out     : DAC master clock, toggles every MCLK_HALF cycles
//   lrck_out     : word select, 0 = left, 1 = right
//   sclk_out     : serial bit clock, period 2*SCLK_HALF cycles
//   sdin_out     : serial data, changes on SCLK falling edges
//   underrun_out : one-cycle pulse on a frame boundary with an empty FIFO
//
// Optional feature (macro I2S_UNDERRUN_HOLD_EN):
//   defined   : on underrun the previous pair is replayed
//   undefined : on underrun silence (zero) is sent
module i2s2_tx #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MCLK_HALF  = 2,
  parameter int unsigned SCLK_HALF  = 16
) (
  input  logic        clk_in,
  input  logic        n_rst_in,
  i2s2_tx_if.slave    sample_if,
  output logic        mclk_out,
  output logic        lrck_out,
  output logic        sclk_out,
  output logic        sdin_out,
  output logic        underrun_out
);

  localparam int unsigned PhW = $clog2(2 * SCLK_HALF);
  localparam int unsigned McW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [PhW-1:0] PhLast  = PhW'(2 * SCLK_HALF - 1);
  localparam logic [PhW-1:0] PhRise  = PhW'(SCLK_HALF);
  localparam logic [McW-1:0] McLast  = McW'(MCLK_HALF - 1);
  localparam logic [CW-1:0]  CntFull = CW'(FIFO_DEPTH);

  // Left-justify to 24 bits: {sample, zeros}, sign bit lands in bit 23.
  function automatic logic [23:0] align24(input logic [WIDTH-1:0] s);
    logic [23:0] w;
    w = '0;
    w[23 -: WIDTH] = s;
    return w;
  endfunction

  // Timing counters
  logic [PhW-1:0] r_ph;
  logic [5:0]     r_b;
  logic [McW-1:0] r_mc;
  logic [PhW-1:0] w_ph_d;
  logic [5:0]     w_b_d;
  logic           w_ph_wrap;
  logic           w_boundary;
  logic           w_boundary_d;

  // FIFO
  logic [WIDTH-1:0] r_fifo_l [FIFO_DEPTH];
  logic [WIDTH-1:0] r_fifo_r [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_d;
  logic             w_push;
  logic             w_pop;

  // Shadow pair being serialised and output registers
  logic [WIDTH-1:0] r_shad_l;
  logic [WIDTH-1:0] r_shad_r;
  logic             r_ready;
  logic             r_mclk;
  logic             r_sclk;
  logic             r_lrck;
  logic             r_sdin;
  logic             r_underrun;

  logic [23:0] w_word;
  logic [4:0]  w_p;
  logic [4:0]  w_bit_idx;
  logic        w_sdin_d;

  always_comb begin
    w_ph_wrap    = (r_ph == PhLast);
    w_ph_d       = w_ph_wrap ? '0 : r_ph + 1'b1;
    w_b_d        = w_ph_wrap ? r_b + 6'd1 : r_b;
    w_boundary   = w_ph_wrap && (r_b == 6'd63);
    w_boundary_d = (w_ph_d == PhLast) && (w_b_d == 6'd63);
  end

  always_comb begin
    w_push = sample_if.sample_valid_in && r_ready;
    w_pop  = w_boundary && (r_count != '0);
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  // Serial bit for the slot about to start. The shadow only changes on the edge into
  // slot position 0, where the output is 0 anyway, so the current shadow is safe to use.
  always_comb begin
    w_word    = w_b_d[5] ? align24(r_shad_r) : align24(r_shad_l);
    w_p       = w_b_d[4:0];
    w_bit_idx = 5'd24 - w_p;
    w_sdin_d  = 1'b0;
    if ((w_p >= 5'd1) && (w_p <= 5'd24)) begin
      w_sdin_d = w_word[w_bit_idx];
    end
  end

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      r_ph   <= '0;
      r_b    <= '0;
      r_mc   <= '0;
      r_mclk <= 1'b0;
      r_sclk <= 1'b0;
      r_lrck <= 1'b0;
      r_sdin <= 1'b0;
    end else begin
      r_ph   <= w_ph_d;
      r_b    <= w_b_d;
      r_sclk <= (w_ph_d >= PhRise);
      r_lrck <= w_b_d[5];
      if (r_mc == McLast) begin
        r_mc   <= '0;
        r_mclk <= ~r_mclk;
      end else begin
        r_mc <= r_mc + 1'b1;
      end
      // Data only moves on the SCLK falling edge (ph wrap).
      if (w_ph_d == '0) begin
        r_sdin <= w_sdin_d;
      end
    end
  end

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_underrun <= 1'b0;
      r_shad_l   <= '0;
      r_shad_r   <= '0;
    end else begin
      r_count    <= w_count_d;
      r_ready    <= (w_count_d != CntFull);
      // Registered from next state so the pulse sits exactly on the boundary cycle.
      r_underrun <= w_boundary_d && (w_count_d == '0);
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr   <= r_rptr + 1'b1;
        r_shad_l <= r_fifo_l[r_rptr];
        r_shad_r <= r_fifo_r[r_rptr];
      end else if (w_boundary) begin
`ifdef I2S_UNDERRUN_HOLD_EN
        r_shad_l <= r_shad_l;
        r_shad_r <= r_shad_r;
`else
        r_shad_l <= '0;
        r_shad_r <= '0;
`endif
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_fifo_l[r_wptr] <= sample_if.sample_l_in;
      r_fifo_r[r_wptr] <= sample_if.sample_r_in;
    end
  end

  assign sample_if.sample_ready_out = r_ready;
  assign mclk_out                   = r_mclk;
  assign sclk_out                   = r_sclk;
  assign lrck_out                   = r_lrck;
  assign sdin_out                   = r_sdin;
  assign underrun_out               = r_underrun;

endmodule
